// File: rtl/mod_dff_arbiter.sv
// Round-robin arbiter that time-shares one bus_t register stage (mod_main) between N_REQ requesters.
// Optional macro ARB_WATCHDOG_EN: idle grants are revoked after TIMEOUT cycles instead of on first release.
package mod_dff_arbiter_pkg;
    typedef logic [11:0] bus_t;  // {tag, data}
endpackage

module mod_dff_arbiter
    import mod_dff_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    input  bus_t              i_D [N_REQ],
    input  logic [N_REQ-1:0]  i_last,
    output logic [N_REQ-1:0]  o_gnt,
    output logic [ID_W-1:0]   o_gnt_id,
    output logic              o_E,
    output bus_t              o_D,
    output logic              o_busy,
    output logic              o_timeout
);

    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 || TIMEOUT < 1) begin : g_param_check
        $error("mod_dff_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_n;
    logic [N_REQ-1:0]   gnt, gnt_n;
    logic [ID_W-1:0]    gnt_id, id_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [3:0]         cnt, cnt_n;
    logic               e, e_n;
    bus_t               d, d_n;
    logic               timeout_n;
    logic               finish;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W:0]      cand;

`ifdef ARB_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]  idle_cnt, idle_n;
    logic               timeout_q;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        id_n      = gnt_id;
        ptr_n     = ptr;
        cnt_n     = cnt;
        e_n       = 1'b0;
        d_n       = d;
        timeout_n = 1'b0;
        finish    = 1'b0;
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
`ifdef ARB_WATCHDOG_EN
        idle_n    = idle_cnt;
`endif

        // Rotating priority search starting at the round-robin pointer.
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (!found && i_req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = N_REQ'(1) << winner;
                    id_n    = winner;
                    cnt_n   = '0;
`ifdef ARB_WATCHDOG_EN
                    idle_n  = '0;
`endif
                end
            end
            GRANT: begin
                if (i_req[gnt_id]) begin
                    e_n   = 1'b1;
                    d_n   = i_D[gnt_id];
                    cnt_n = cnt + 4'd1;
`ifdef ARB_WATCHDOG_EN
                    idle_n = '0;
`endif
                    if (i_last[gnt_id] || cnt == 4'(MAX_BURST - 1)) finish = 1'b1;
                end else begin
`ifdef ARB_WATCHDOG_EN
                    idle_n = idle_cnt + 1'b1;
                    if (idle_n == IDLE_W'(TIMEOUT)) begin
                        finish    = 1'b1;
                        timeout_n = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
                if (finish) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            e         <= 1'b0;
            d         <= '0;
`ifdef ARB_WATCHDOG_EN
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            e         <= e_n;
            d         <= d_n;
`ifdef ARB_WATCHDOG_EN
            idle_cnt  <= idle_n;
            timeout_q <= timeout_n;
`endif
        end
    end

    assign o_gnt    = gnt;
    assign o_gnt_id = gnt_id;
    assign o_E      = e;
    assign o_D      = d;
    assign o_busy   = (state == GRANT);
`ifdef ARB_WATCHDOG_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout_n;
`endif

endmodule

// File: doc/mod_dff_arbiter.md
Name: mod_dff_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single Bus_t D-type flip-flop stage (mod_main) between N requesters.
- Grants one requester at a time for a burst of beats.
- Drives the register's enable and data inputs (o_E/o_D feed i_E/i_D) and returns a one-hot grant to the requesters.
- Sits between the requester blocks and mod_main; mod_main's i_clk is the same clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant before forced hand-over (1..15).
- TIMEOUT, 8, idle-grant cycles before revocation (used only with ARB_WATCHDOG_EN).

Ports:
- i_clk  input  1  system clock, all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  N_REQ  per-requester request/valid; a beat occurs when i_req[g] & o_gnt[g] at a clock edge.
- i_D  input  N_REQ x Bus_t (12b each, {tag,data} from definitions.svh)  per-requester data, unpacked array.
- i_last  input  N_REQ  marks the final beat of a requester's burst.
- o_gnt  output  N_REQ  registered one-hot grant, all-zero when idle.
- o_gnt_id  output  $clog2(N_REQ)  index of the current/last grantee.
- o_E  output  1  registered enable to mod_main i_E.
- o_D  output  Bus_t  registered data to mod_main i_D.
- o_busy  output  1  high while in GRANT state.
- o_timeout  output  1  one-cycle pulse when a grant is revoked (see Optional Feature).

Behaviour:
- Reset (i_rst=1 at posedge, any state, mid-burst included): state=IDLE, o_gnt=0, o_gnt_id=0, o_E=0, o_D=12'b0, o_busy=0, o_timeout=0, rr pointer=0, beat counter=0. Reset overrides all other inputs.
- FSM states: IDLE and GRANT.
- IDLE:
  - If |i_req: winner = first requester with i_req set, searching from the pointer upward with wrap (N_REQ-1 -> 0).
  - Next cycle: o_gnt=onehot(winner), o_gnt_id=winner, o_busy=1, counter=0, state=GRANT.
  - If no request: stay in IDLE.
  - Grant latency: 1 cycle from request to o_gnt.
- GRANT (grantee g):
  - Each cycle with i_req[g]=1 is a beat: next cycle o_E=1, o_D=i_D[g], counter+1.
  - Non-beat cycle: next cycle o_E=0, o_D holds its previous value. Since mod_main's else branch clears o_Q, an idle cycle zeroes the register.
- End of burst, evaluated at the same edge:
  - Triggers: beat with i_last[g]=1; beat with counter==MAX_BURST-1; or i_req[g]=0 (requester release).
  - Actions: o_gnt=0, o_busy=0, pointer=(g+1) mod N_REQ, state=IDLE.
  - The beat that ends a burst is still forwarded. A release cycle forwards nothing.
- Hand-over gap: exactly one IDLE cycle between bursts, even when other requests are pending. Max bus utilisation is MAX_BURST/(MAX_BURST+1).
- Requests from non-granted requesters are ignored (no beat, no data capture) until they win arbitration.
- End-to-end latency: beat edge -> o_E/o_D next cycle -> mod_main o_Q one cycle later (2 cycles total).
- o_gnt is always one-hot or zero. o_gnt_id is held in IDLE.
- Mid-burst changes to i_D[g] are sampled per beat; there is no internal buffering.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - GRANT holds an idle-cycle counter, cleared on every beat and incremented on every cycle with i_req[g]=0. In this mode, i_req[g]=0 does not end the burst.
  - When the counter reaches TIMEOUT, the grant is revoked: o_gnt=0, pointer=g+1, state=IDLE, o_timeout=1 for one cycle.
  - Normal i_last and MAX_BURST ends are unchanged.
- Undefined: o_timeout tied 0, no counter, and i_req[g]=0 ends the burst immediately as described above.

Test Plan:
- Reset, then i_req=4'b0001, i_D[0]=12'hA5C, i_last[0]=1 for one beat -> o_gnt=0001 at cycle+1; o_E=1, o_D=12'hA5C at cycle+2; mod_main o_Q=12'hA5C and o_nQ=12'h5A3 at cycle+3; o_gnt=0 after the beat.
- i_req=4'b1111 held continuously, i_last=0 -> bursts of exactly 4 beats each, granted in order 0,1,2,3,0, with one idle cycle between grants.
- Pointer=2 and i_req=4'b0011 -> requester 0 granted (wrap search), then requester 1.
- Reset asserted mid-burst (beat 2 of requester 1) -> next cycle all outputs at reset values and pointer=0; with i_req=4'b0010 still high, requester 1 is re-granted after reset deasserts.
- Requester 3 granted, drops i_req after 1 beat -> without macro: grant released next edge, o_E=0 after. With ARB_WATCHDOG_EN and TIMEOUT=8: o_gnt held 8 cycles, then o_timeout pulses once and o_gnt=0.
